tfhe_c2h_result_streamer: RTL and testbench
===========================================

// Module: tfhe_c2h_result_streamer
// PURPOSE
//  Device-to-host readback engine: reads a contiguous ciphertext result region from HBM via an AXI4 read master
//  and emits it as a packetised AXI-Stream to the PCIe C2H channel. Inverse direction of the H2C load path.
//  Sits between the HBM AXI port and the PCIe DMA C2H stream inside the TFHE-PU block design.
// PARAMETERS
//  ADDR_W     64   AXI address width (byte address)
//  DATA_W     256  AXI data / stream width; bytes per beat BPB = DATA_W/8
//  LEN_W      20   width of beat-count command field
//  MAX_BURST  16   max beats per AR burst (power of 2, 1..256)
//  FIFO_DEPTH 32   read-data buffer depth in beats (power of 2, >= MAX_BURST)
// PORTS
//  clk            in  1       single clock for all logic
//  reset          in  1       synchronous, active-high
//  cmd_valid      in  1       start request; accepted when cmd_ready=1
//  cmd_ready      out 1       high only in IDLE
//  cmd_addr       in  ADDR_W  start byte address, BPB-aligned
//  cmd_beats      in  LEN_W   beats to transfer; 0 = no transfer
//  m_axi_ar*      out -       araddr[ADDR_W], arlen[8], arsize=log2(BPB), arburst=INCR, arvalid; arready in
//  m_axi_r*       in  -       rdata[DATA_W], rresp[2], rlast, rvalid; rready out
//  m_axis_tdata   out DATA_W  C2H stream data
//  m_axis_tkeep   out DATA_W/8 all ones
//  m_axis_tlast   out 1       high on final beat of command
//  m_axis_tvalid  out 1 / m_axis_tready in 1   stream handshake
//  done           out 1       one-cycle pulse after last beat accepted downstream
//  err            out 1       sticky: any rresp != OKAY; cleared by next accepted cmd
// BEHAVIOUR
//  Reset: cmd_ready=0 during reset then 1; arvalid=0, rready=0, tvalid=0, tlast=0, done=0, err=0; FIFO emptied.
//  FSM: IDLE -> (cmd_valid&cmd_ready, beats!=0) AR -> (arvalid&arready) WAIT_R -> more beats left ? AR : DRAIN -> DONE -> IDLE.
//   beats==0: IDLE -> DONE directly; done pulses, no AR, no stream beat.
//  Burst sizing: arlen+1 = min(MAX_BURST, remaining, beats to next 4 KB boundary); no burst crosses 4 KB.
//  Credit: AR issued only if FIFO free slots >= burst beats (count reserved slots incl. outstanding); one burst outstanding max.
//  arvalid held with stable araddr/arlen until arready; araddr advances by (arlen+1)*BPB after handshake.
//  rready=1 in WAIT_R always (space reserved); R beats pushed in order; rlast ends WAIT_R.
//  rresp SLVERR/DECERR: err set, data still forwarded, transfer length unchanged.
//  Stream: FIFO head drives tdata; tvalid=!empty; tdata/tlast stable while tvalid&!tready.
//   tlast computed from downstream beat counter == cmd_beats-1 (not from rlast).
//  Latency: first AR cycle after cmd accept; R beat -> tvalid next cycle (registered FIFO).
//  FIFO full/empty simultaneous push+pop allowed; count unchanged.
//  DONE: done=1 for exactly one cycle, cmd_ready returns 1 the following cycle.
//  cmd_valid while busy ignored (cmd_ready=0). Reset mid-operation aborts: state IDLE, FIFO flushed,
//   outstanding R beats after reset are still accepted and discarded only if interconnect is also reset (system requirement).
//  Beat counters LEN_W bits; cmd_beats max 2^LEN_W-1, no wrap within a command.
// CONFIGURATION
//  C2H_PERF_CNT_EN defined: adds output perf_cycles[31:0] = cycles from cmd accept to done (inclusive), latched at done,
//   saturates at 0xFFFFFFFF, reset 0; plus perf_stall[31:0] = cycles with tvalid&!tready in same window.
//  Not defined: ports and counters absent; no other behavioural change.
// TESTING
//  addr=0x0, beats=16, tready=1 -> one AR arlen=15, 16 beats out in order, tlast on beat 16, one done pulse.
//  addr=0xFC0 (BPB=32), beats=8 -> AR1 arlen=1 @0xFC0, AR2 arlen=5 @0x1000; no 4 KB crossing.
//  beats=40, tready toggles 1/0 random, arready delayed 3 cycles -> data intact, tdata stable under stall, tlast beat 40.
//  beat 5 of 16 rresp=SLVERR -> err=1 sticky, 16 beats still output, cleared on next cmd accept.
//  beats=0 -> done pulses within 2 cycles, no arvalid, no tvalid.
//  reset asserted mid-transfer of beats=64 -> next cycle all outputs at reset values; new cmd beats=4 completes cleanly.

Source files
------------

// File: rtl/tfhe_c2h_result_streamer.sv
// HBM-to-PCIe C2H readback: AXI4 INCR bursts (<=MAX_BURST, never across 4 KB) into a beat FIFO, out as AXI-Stream.
// Latency: AR one cycle after cmd accept; R beat appears on the stream the following cycle.
// Backpressure: AR is issued only when the FIFO can absorb the whole burst, so rready never stalls. Option: C2H_PERF_CNT_EN.
module tfhe_c2h_result_streamer #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 256,
    parameter int LEN_W      = 20,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [LEN_W-1:0]    cmd_beats_i,
    output logic [ADDR_W-1:0]   m_axi_araddr_o,
    output logic [7:0]          m_axi_arlen_o,
    output logic [2:0]          m_axi_arsize_o,
    output logic [1:0]          m_axi_arburst_o,
    output logic                m_axi_arvalid_o,
    input  logic                m_axi_arready_i,
    input  logic [DATA_W-1:0]   m_axi_rdata_i,
    input  logic [1:0]          m_axi_rresp_i,
    input  logic                m_axi_rlast_i,
    input  logic                m_axi_rvalid_i,
    output logic                m_axi_rready_o,
    output logic [DATA_W-1:0]   m_axis_tdata_o,
    output logic [DATA_W/8-1:0] m_axis_tkeep_o,
    output logic                m_axis_tlast_o,
    output logic                m_axis_tvalid_o,
    input  logic                m_axis_tready_i,
`ifdef C2H_PERF_CNT_EN
    output logic [31:0]         perf_cycles_o,
    output logic [31:0]         perf_stall_o,
    output logic                done_o,
    output logic                err_o
`else
    output logic                done_o,
    output logic                err_o
`endif
);
    localparam int BPB  = DATA_W / 8;
    localparam int SIZE = $clog2(BPB);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_WAIT_R, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic                cmd_rdy_q, arvalid_q, rready_q, done_q, err_q;
    logic [ADDR_W-1:0]   araddr_q, addr_q;
    logic [7:0]          arlen_q;
    logic [LEN_W-1:0]    rem_q, beats_q, out_cnt_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         cnt_q, cnt_d;

    logic                cmd_acc, push, pop, tvalid, tlast;
    logic [11:0]         src_lo;
    logic [LEN_W-1:0]    src_rem;
    logic [12:0]         to_bnd, bnd_beats;
    logic [8:0]          blen;
    logic [ADDR_W-1:0]   burst_bytes;

    assign cmd_acc = (state_q == S_IDLE) && cmd_valid_i && cmd_rdy_q;
    assign push    = m_axi_rvalid_i && rready_q;
    assign tvalid  = (cnt_q != '0);
    assign pop     = tvalid && m_axis_tready_i;
    assign tlast   = tvalid && (out_cnt_q == beats_q - LEN_W'(1));

    // Burst size: smallest of MAX_BURST, beats remaining, beats left before the next 4 KB page.
    always_comb begin
        src_lo    = (state_q == S_IDLE) ? cmd_addr_i[11:0] : addr_q[11:0];
        src_rem   = (state_q == S_IDLE) ? cmd_beats_i : rem_q;
        to_bnd    = 13'h1000 - {1'b0, src_lo};
        bnd_beats = to_bnd >> SIZE;
        blen      = 9'(MAX_BURST);
        if (32'(bnd_beats) < 32'(blen)) blen = bnd_beats[8:0];
        if (32'(src_rem) < 32'(blen))   blen = src_rem[8:0];
    end

    assign burst_bytes = (ADDR_W'(arlen_q) + ADDR_W'(1)) << SIZE;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cmd_rdy_q <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (push && (m_axi_rresp_i != 2'b00)) err_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (cmd_acc) begin
                        cmd_rdy_q <= 1'b0;
                        err_q     <= 1'b0;
                        beats_q   <= cmd_beats_i;
                        addr_q    <= cmd_addr_i;
                        rem_q     <= cmd_beats_i;
                        if (cmd_beats_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_AR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= cmd_addr_i;
                            arlen_q   <= 8'(blen - 9'd1);
                        end
                    end else begin
                        cmd_rdy_q <= 1'b1;
                    end
                end
                S_AR: begin
                    if (arvalid_q) begin
                        if (m_axi_arready_i) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            addr_q    <= addr_q + burst_bytes;
                            rem_q     <= rem_q - (LEN_W'(arlen_q) + LEN_W'(1));
                            state_q   <= S_WAIT_R;
                        end
                    // Nothing is outstanding here, so free slots are just depth minus occupancy.
                    end else if (32'(FIFO_DEPTH) - 32'(cnt_q) >= 32'(blen)) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= addr_q;
                        arlen_q   <= 8'(blen - 9'd1);
                    end
                end
                S_WAIT_R: begin
                    if (push && m_axi_rlast_i) begin
                        rready_q <= 1'b0;
                        state_q  <= (rem_q != '0) ? S_AR : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && tlast) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    cmd_rdy_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (cmd_acc)  out_cnt_q <= '0;
            else if (pop) out_cnt_q <= out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= m_axi_rdata_i;
    end

`ifdef C2H_PERF_CNT_EN
    logic [31:0] run_cyc_q, run_stall_q, perf_cycles_q, perf_stall_q;

    // The accept cycle counts as the first cycle; the DONE cycle is added when latching.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            run_cyc_q     <= '0;
            run_stall_q   <= '0;
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (cmd_acc) begin
            run_cyc_q   <= 32'd1;
            run_stall_q <= '0;
        end else if (state_q == S_DONE) begin
            perf_cycles_q <= (run_cyc_q == '1) ? run_cyc_q : run_cyc_q + 32'd1;
            perf_stall_q  <= run_stall_q;
        end else if (state_q != S_IDLE) begin
            if (run_cyc_q != '1) run_cyc_q <= run_cyc_q + 32'd1;
            if (tvalid && !m_axis_tready_i && (run_stall_q != '1)) run_stall_q <= run_stall_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stall_o  = perf_stall_q;
`endif

    assign cmd_ready_o     = cmd_rdy_q;
    assign m_axi_araddr_o  = araddr_q;
    assign m_axi_arlen_o   = arlen_q;
    assign m_axi_arsize_o  = 3'(SIZE);
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_rready_o  = rready_q;
    assign m_axis_tdata_o  = mem_q[rd_ptr_q];
    assign m_axis_tkeep_o  = '1;
    assign m_axis_tlast_o  = tlast;
    assign m_axis_tvalid_o = tvalid;
    assign done_o          = done_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_tfhe_c2h_result_streamer.sv
// Bench for tfhe_c2h_result_streamer: AXI read slave, stream sink and a queue-based model of the expected bursts/beats.
module tb_tfhe_c2h_result_streamer;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 20;
    localparam int BPB    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_i, cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_addr, araddr;
    logic [LEN_W-1:0]  cmd_beats;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst, rresp;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] rdata, tdata;
    logic [31:0]       tkeep;
    logic              tlast, tvalid, tready, done, err;

    tfhe_c2h_result_streamer dut (
        .clk_i(clk), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_beats_i(cmd_beats),
        .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst),
        .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast), .m_axi_rvalid_i(rvalid),
        .m_axi_rready_o(rready),
        .m_axis_tdata_o(tdata), .m_axis_tkeep_o(tkeep), .m_axis_tlast_o(tlast), .m_axis_tvalid_o(tvalid),
        .m_axis_tready_i(tready), .done_o(done), .err_o(err)
    );

    typedef struct { logic [DATA_W-1:0] d; logic l; } beat_t;
    typedef struct { logic [ADDR_W-1:0] a; logic [7:0] len; } ar_t;

    beat_t exp_q[$];
    ar_t   exp_ar[$];
    ar_t   ar_log[$];

    int checks = 0;
    int errors = 0;
    int acc_beats = 0, tv_seen = 0, ar_seen = 0, done_seen = 0;
    int err_beat = -1, ar_delay = 0, tr_mode = 0;

    // negedge samples consumed by the slave on the following posedge
    logic              ar_hs_s = 1'b0, r_hs_s = 1'b0;
    logic [ADDR_W-1:0] ar_a_s;
    logic [7:0]        ar_len_s;
    int                s_beat = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [31:0] x, y;
        x = a[31:0] ^ 32'h5A5A_0000;
        y = ~a[31:0] + 32'd7;
        return {4{x, y}};
    endfunction

    // Expected stream: one beat per BPB address, tlast on the final one; bursts split at 16 beats and 4 KB pages.
    task automatic model_push(input logic [ADDR_W-1:0] a, input int n);
        logic [ADDR_W-1:0] ad;
        int rem, len, bnd;
        beat_t b;
        ar_t   r;
        exp_q.delete();
        exp_ar.delete();
        for (int i = 0; i < n; i++) begin
            b.d = pat(a + 64'(i * BPB));
            b.l = (i == n - 1);
            exp_q.push_back(b);
        end
        ad  = a;
        rem = n;
        while (rem > 0) begin
            bnd = (4096 - int'(ad % 4096)) / BPB;
            len = 16;
            if (rem < len) len = rem;
            if (bnd < len) len = bnd;
            r.a   = ad;
            r.len = 8'(len - 1);
            exp_ar.push_back(r);
            ad  = ad + 64'(len * BPB);
            rem = rem - len;
        end
    endtask

    // AXI read slave and stream sink
    initial begin : slave
        logic [ADDR_W-1:0] s_addr;
        int  s_left, ar_wait;
        bit  s_busy;
        s_addr = '0; s_left = 0; ar_wait = 0; s_busy = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (reset_i) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                s_busy = 0; ar_wait = 0;
            end else begin
                if (r_hs_s) begin
                    s_left--;
                    s_addr = s_addr + 64'(BPB);
                    s_beat++;
                    if (s_left == 0) s_busy = 0;
                end
                if (ar_hs_s) begin
                    arready = 1'b0;
                    ar_wait = 0;
                    s_busy  = 1;
                    s_addr  = ar_a_s;
                    s_left  = int'(ar_len_s) + 1;
                end else if (arvalid && !arready) begin
                    if (ar_wait >= ar_delay) arready = 1'b1;
                    else ar_wait++;
                end
                if (s_busy) begin
                    rvalid = 1'b1;
                    rdata  = pat(s_addr);
                    rresp  = (s_beat == err_beat) ? 2'b10 : 2'b00;
                    rlast  = (s_left == 1);
                end else begin
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                end
            end
            tready = (tr_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
    end

    // Per-cycle compare against the model
    initial begin : monitor
        logic              p_stall, p_arw, p_last;
        logic [DATA_W-1:0] p_data;
        logic [ADDR_W-1:0] p_araddr;
        logic [7:0]        p_arlen;
        beat_t b;
        ar_t   r;
        p_stall = 0; p_arw = 0; p_last = 0; p_data = '0; p_araddr = '0; p_arlen = '0;
        forever begin
            @(negedge clk);
            ar_hs_s  = arvalid && arready;
            ar_a_s   = araddr;
            ar_len_s = arlen;
            r_hs_s   = rvalid && rready;
            if (reset_i) begin
                p_stall = 0;
                p_arw   = 0;
            end else begin
                if (p_stall) begin
                    chk("tvalid_hold", tvalid, 1);
                    chk("tdata_stable", tdata, p_data);
                    chk("tlast_stable", tlast, p_last);
                end
                if (p_arw) begin
                    chk("arvalid_hold", arvalid, 1);
                    chk("araddr_stable", araddr, p_araddr);
                    chk("arlen_stable", arlen, p_arlen);
                end
                if (tvalid) begin
                    tv_seen++;
                    if (tready) begin
                        acc_beats++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL extra_beat actual=%0h required=none", tdata);
                        end else begin
                            b = exp_q.pop_front();
                            chk("tdata", tdata, b.d);
                            chk("tlast", tlast, b.l);
                            chk("tkeep", tkeep, 32'hFFFF_FFFF);
                        end
                    end
                end
                if (arvalid) ar_seen++;
                if (arvalid && arready) begin
                    r.a = araddr; r.len = arlen;
                    ar_log.push_back(r);
                    if (exp_ar.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_ar actual=%0h required=none", araddr);
                    end else begin
                        r = exp_ar.pop_front();
                        chk("araddr", araddr, r.a);
                        chk("arlen", arlen, r.len);
                        chk("arsize", arsize, 3'd5);
                        chk("arburst", arburst, 2'b01);
                    end
                end
                if (done) done_seen++;
                p_stall = tvalid && !tready; p_data = tdata; p_last = tlast;
                p_arw = arvalid && !arready; p_araddr = araddr; p_arlen = arlen;
            end
        end
    end

    task automatic issue_cmd(input logic [ADDR_W-1:0] a, input int n);
        bit got;
        model_push(a, n);
        ar_log.delete();
        acc_beats = 0;
        done_seen = 0;
        s_beat    = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = LEN_W'(n);
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1; break; end
        end
        chk("cmd_accept", got, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        if (n != 0) chk("ar_first_cycle", arvalid, 1);
        else        chk("done_latency", done, 1);
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("err_cleared", err, 0);
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin got = 1; break; end
            @(negedge clk);
        end
        chk("done_seen", got, 1);
        chk("beats_left", exp_q.size(), 0);
        chk("ars_left", exp_ar.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("done_count", done_seen, 1);
    endtask

    initial begin : main
        int ar0, tv0;
        reset_i = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // single aligned burst
        issue_cmd(64'h0, 16);
        wait_done(200);
        chk("t1_beats", acc_beats, 16);
        chk("t1_ar_cnt", ar_log.size(), 1);
        if (ar_log.size() == 1) begin
            chk("t1_ar_addr", ar_log[0].a, 64'h0);
            chk("t1_ar_len", ar_log[0].len, 8'd15);
        end

        // 4 KB boundary split
        issue_cmd(64'hFC0, 8);
        wait_done(200);
        chk("t2_ar_cnt", ar_log.size(), 2);
        if (ar_log.size() == 2) begin
            chk("t2_ar0_addr", ar_log[0].a, 64'hFC0);
            chk("t2_ar0_len", ar_log[0].len, 8'd1);
            chk("t2_ar1_addr", ar_log[1].a, 64'h1000);
            chk("t2_ar1_len", ar_log[1].len, 8'd5);
        end

        // random downstream stalls, slow arready
        tr_mode = 1; ar_delay = 3;
        issue_cmd(64'h3F00, 40);
        wait_done(2000);
        chk("t3_beats", acc_beats, 40);
        chk("t3_ar_cnt", ar_log.size(), 3);
        tr_mode = 0; ar_delay = 0;

        // SLVERR on beat 5 of 16
        err_beat = 4;
        issue_cmd(64'h5000, 16);
        wait_done(200);
        err_beat = -1;
        chk("t4_beats", acc_beats, 16);
        chk("t4_err_set", err, 1);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", err, 1);

        // zero-length command also clears err
        ar0 = ar_seen; tv0 = tv_seen;
        issue_cmd(64'h0, 0);
        wait_done(5);
        chk("t5_no_ar", ar_seen - ar0, 0);
        chk("t5_no_tvalid", tv_seen - tv0, 0);

        // reset mid-transfer, then a clean short command
        tr_mode = 1;
        issue_cmd(64'h8000, 64);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        exp_q.delete();
        exp_ar.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_arvalid", arvalid, 0);
        chk("abort_rready", rready, 0);
        chk("abort_tvalid", tvalid, 0);
        chk("abort_tlast", tlast, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        tr_mode = 0;
        repeat (2) @(posedge clk);
        issue_cmd(64'h100, 4);
        wait_done(200);
        chk("t6_beats", acc_beats, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
